// File: rtl/effects_param_scheduler.sv
// -----------------------------------------------------------------------------
// effects_param_scheduler
//
// Schedules gain updates for the effects pipeline on audio sample boundaries.
// A free-running tick counter divides clk down to the sample rate and emits a
// one-cycle o_valid strobe. Gain writes land in a one-entry pending slot and
// are applied only on a tick, so o_par_gain changes only on the edge that ends
// an o_valid cycle.
//
// Build option:
//   PARAM_RAMP_EN  defined   -> gain slews toward the requested value by at
//                               most RAMP_STEP per tick (IDLE/WAIT_TICK/RAMP).
//                  undefined -> requested gain is applied in one step on the
//                               next tick (IDLE/WAIT_TICK only).
//
// Parameters:
//   CLK_DIV     clock cycles per sample period (>= 2)
//   GAIN_W      gain word width
//   RAMP_STEP   largest gain change per tick (1 .. 2**GAIN_W-1)
//   RESET_GAIN  gain driven while and after reset
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   i_wr_valid   gain write offered
//   i_wr_gain    requested gain (unsigned)
//   o_wr_ready   pending slot empty, write accepted this edge if offered
//   o_valid      one-cycle sample strobe for the effects pipeline
//   o_par_gain   gain for the effects pipeline
//   o_busy       FSM is not IDLE
//   dbg_state    current FSM state encoding, for observation only
//
// Write handshake: a write transfers on a rising edge where i_wr_valid and
// o_wr_ready are both 1. The requester keeps i_wr_valid and i_wr_gain steady
// until that edge; o_wr_ready does not depend on i_wr_valid.
// -----------------------------------------------------------------------------
module effects_param_scheduler #(
   parameter int CLK_DIV    = 1024,
   parameter int GAIN_W     = 10,
   parameter int RAMP_STEP  = 8,
   parameter int RESET_GAIN = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_valid,
   input  logic [GAIN_W-1:0] i_wr_gain,
   output logic              o_wr_ready,
   output logic              o_valid,
   output logic [GAIN_W-1:0] o_par_gain,
   output logic              o_busy,
   output logic [1:0]        dbg_state
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   // Elaboration-time guard on the parameter ranges.
   generate
      if (CLK_DIV < 2 || RAMP_STEP < 1 || RAMP_STEP > (2 ** GAIN_W) - 1) begin : g_param_check
         $error("effects_param_scheduler: CLK_DIV or RAMP_STEP out of range");
      end
   endgenerate

`ifdef PARAM_RAMP_EN
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TICK = 2'd1,
      ST_RAMP      = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TICK = 2'd1
   } state_t;
`endif

   state_t              state;
   state_t              state_nx;

   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;

   logic                pend_full;
   logic [GAIN_W-1:0]   pend_gain;
   logic                pend_clr;
   logic                wr_acc;

   logic [GAIN_W-1:0]   gain_q;
   logic                gain_ld;
   logic [GAIN_W-1:0]   gain_nx;

   // --------------------------------------------------------------------------
   // Sample tick divider
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (tick_cnt == CNT_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   assign tick = (tick_cnt == CNT_LAST);

   // --------------------------------------------------------------------------
   // One-entry pending slot. Accept and clear are mutually exclusive: a clear
   // needs the slot full, an accept needs it empty. A write accepted on a tick
   // edge is therefore never consumed by that same tick.
   // --------------------------------------------------------------------------
   assign wr_acc = i_wr_valid & ~pend_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_full <= 1'b0;
         pend_gain <= '0;
      end else if (wr_acc) begin
         pend_full <= 1'b1;
         pend_gain <= i_wr_gain;
      end else if (pend_clr) begin
         pend_full <= 1'b0;
      end
   end

`ifdef PARAM_RAMP_EN
   // --------------------------------------------------------------------------
   // Ramp arithmetic. Distance is formed one bit wider than the gain so the
   // comparison against the step never wraps. When the distance exceeds the
   // step, gain +/- step stays inside [0, 2**GAIN_W-1] by construction, so
   // the stepped value can be formed at GAIN_W bits.
   // --------------------------------------------------------------------------
   localparam logic [GAIN_W:0]   STEP_X = (GAIN_W + 1)'(RAMP_STEP);
   localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(RAMP_STEP);

   logic [GAIN_W-1:0] target_q;
   logic              target_ld;
   logic [GAIN_W-1:0] target_nx;
   logic [GAIN_W:0]   gain_x;
   logic [GAIN_W:0]   target_x;
   logic [GAIN_W:0]   dist;
   logic              ramp_up;
   logic              ramp_near;
   logic [GAIN_W-1:0] ramp_gain;

   assign gain_x    = {1'b0, gain_q};
   assign target_x  = {1'b0, target_q};
   assign ramp_up   = (target_x > gain_x);
   assign dist      = ramp_up ? (target_x - gain_x) : (gain_x - target_x);
   assign ramp_near = (dist <= STEP_X);
   assign ramp_gain = ramp_near ? target_q
                    : (ramp_up ? (gain_q + STEP_G) : (gain_q - STEP_G));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target_q <= GAIN_W'(RESET_GAIN);
      end else if (target_ld) begin
         target_q <= target_nx;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state and update strobes. Every gain load is gated by tick so
   // the output gain only moves on the edge closing an o_valid cycle.
   // --------------------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      pend_clr  = 1'b0;
      gain_ld   = 1'b0;
      gain_nx   = gain_q;
`ifdef PARAM_RAMP_EN
      target_ld = 1'b0;
      target_nx = target_q;
`endif
      case (state)
         ST_IDLE: begin
            if (wr_acc) begin
               state_nx = ST_WAIT_TICK;
            end
         end

         ST_WAIT_TICK: begin
            if (tick) begin
               pend_clr = 1'b1;
`ifdef PARAM_RAMP_EN
               target_ld = 1'b1;
               target_nx = pend_gain;
               state_nx  = ST_RAMP;
`else
               gain_ld  = 1'b1;
               gain_nx  = pend_gain;
               state_nx = ST_IDLE;
`endif
            end
         end

`ifdef PARAM_RAMP_EN
         ST_RAMP: begin
            if (tick) begin
               gain_ld = 1'b1;
               gain_nx = ramp_gain;
               // A waiting write always retargets on this tick, whether or not
               // the current target was just reached; the step taken on this
               // tick still heads toward the old target.
               if (pend_full) begin
                  pend_clr  = 1'b1;
                  target_ld = 1'b1;
                  target_nx = pend_gain;
               end else if (ramp_near) begin
                  state_nx = ST_IDLE;
               end
            end
         end
`endif

         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output gain register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gain_q <= GAIN_W'(RESET_GAIN);
      end else if (gain_ld) begin
         gain_q <= gain_nx;
      end
   end

   assign o_valid    = tick;
   assign o_wr_ready = ~pend_full;
   assign o_par_gain = gain_q;
   assign o_busy     = (state != ST_IDLE);
   assign dbg_state  = state;

endmodule

// File: tb/tb_effects_param_scheduler.sv
// -----------------------------------------------------------------------------
// tb_effects_param_scheduler
//
// Directed bench for effects_param_scheduler with CLK_DIV=4, RAMP_STEP=8,
// RESET_GAIN=80. Works for both builds (PARAM_RAMP_EN defined or not); the
// expected gain sequences differ per build and are written out by hand.
// Inputs are driven and outputs sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_effects_param_scheduler;

   localparam int GW = 10;

   logic          clk        = 1'b0;
   logic          rst        = 1'b0;
   logic          i_wr_valid = 1'b0;
   logic [GW-1:0] i_wr_gain  = '0;
   logic          o_wr_ready;
   logic          o_valid;
   logic [GW-1:0] o_par_gain;
   logic          o_busy;
   logic [1:0]    dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   // Gain after each tick of the 200-then-40 scenario with ramping: the tick
   // that sees 40 pending still steps toward 200 (80->88), then slews down.
   int seq40 [7] = '{88, 80, 72, 64, 56, 48, 40};

   effects_param_scheduler #(
      .CLK_DIV    (4),
      .GAIN_W     (GW),
      .RAMP_STEP  (8),
      .RESET_GAIN (80)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_wr_valid (i_wr_valid),
      .i_wr_gain  (i_wr_gain),
      .o_wr_ready (o_wr_ready),
      .o_valid    (o_valid),
      .o_par_gain (o_par_gain),
      .o_busy     (o_busy),
      .dbg_state  (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Advance through the next tick edge, checking the gain holds until then.
   task automatic wait_tick(input string tag);
      logic [GW-1:0] held;
      int n;
      held = o_par_gain;
      n = 0;
      while (o_valid !== 1'b1 && n < 12) begin
         check({tag, "_hold"}, o_par_gain, held);
         cyc();
         n++;
      end
      check({tag, "_tick_seen"}, o_valid, 1);
      check({tag, "_hold_at_tick"}, o_par_gain, held);
      cyc();
   endtask

   task automatic do_write(input logic [GW-1:0] g, input string tag);
      int n;
      n = 0;
      i_wr_valid = 1'b1;
      i_wr_gain  = g;
      while (o_wr_ready !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      check({tag, "_ready"}, o_wr_ready, 1);
      cyc();
      i_wr_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gain"},  o_par_gain, 80);
      check({tag, "_valid"}, o_valid,    0);
      check({tag, "_busy"},  o_busy,     0);
      check({tag, "_ready"}, o_wr_ready, 1);
   endtask

   // Assert reset asynchronously, check forced outputs, release.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check_reset_outputs(tag);
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      // Reset release with no writes: o_valid at cycles 3, 7, 11.
      cyc();
      cyc();
      check_reset_outputs("por");
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         check("rel_valid", o_valid, (c % 4) == 3);
         check("rel_gain",  o_par_gain, 80);
         check("rel_ready", o_wr_ready, 1);
         check("rel_busy",  o_busy, 0);
         cyc();
      end

      // Small change 80 -> 84, below one step.
      do_write(84, "w84");
      check("w84_busy",  o_busy, 1);
      check("w84_full",  o_wr_ready, 0);
      check("w84_gain0", o_par_gain, 80);
`ifdef PARAM_RAMP_EN
      wait_tick("w84_load");
      check("w84_load_gain", o_par_gain, 80);
      check("w84_load_busy", o_busy, 1);
      check("w84_load_ready", o_wr_ready, 1);
`endif
      wait_tick("w84_apply");
      check("w84_gain", o_par_gain, 84);
      check("w84_idle", o_busy, 0);

      // Single write of 120 from 80.
      do_reset("rst_a");
      do_write(120, "w120");
      check("w120_busy", o_busy, 1);
      check("w120_gain0", o_par_gain, 80);
`ifdef PARAM_RAMP_EN
      wait_tick("w120_load");
      check("w120_load_gain", o_par_gain, 80);
      check("w120_load_busy", o_busy, 1);
      for (int v = 88; v <= 120; v += 8) begin
         wait_tick("w120_ramp");
         check("w120_ramp_gain", o_par_gain, v);
         check("w120_ramp_busy", o_busy, v != 120);
      end
`else
      wait_tick("w120_apply");
      check("w120_gain", o_par_gain, 120);
      check("w120_idle", o_busy, 0);
`endif
      wait_tick("w120_settled");
      check("w120_settled_gain", o_par_gain, 120);
      check("w120_settled_busy", o_busy, 0);

      // Back-to-back 200 then 40; 40 waits for the slot to drain.
      do_reset("rst_b");
      do_write(200, "w200");
      i_wr_valid = 1'b1;
      i_wr_gain  = 40;
      for (int n = 0; n < 12 && o_valid !== 1'b1; n++) begin
         check("w40_held", o_wr_ready, 0);
         cyc();
      end
      check("w40_tick_seen", o_valid, 1);
      check("w40_held_at_tick", o_wr_ready, 0);
      cyc();
      check("w40_ready_after_tick", o_wr_ready, 1);
`ifdef PARAM_RAMP_EN
      check("w200_load_gain", o_par_gain, 80);
      check("w200_load_busy", o_busy, 1);
`else
      check("w200_gain", o_par_gain, 200);
      check("w200_idle", o_busy, 0);
`endif
      cyc();
      i_wr_valid = 1'b0;
      check("w40_taken", o_wr_ready, 0);
      check("w40_busy", o_busy, 1);
`ifdef PARAM_RAMP_EN
      for (int k = 0; k < 7; k++) begin
         wait_tick("w40_ramp");
         check("w40_ramp_gain", o_par_gain, seq40[k]);
         check("w40_ramp_busy", o_busy, k != 6);
      end
`else
      wait_tick("w40_apply");
      check("w40_gain", o_par_gain, 40);
      check("w40_idle", o_busy, 0);
`endif

      // Reset while work is outstanding; nothing may survive release.
      do_reset("rst_c");
      do_write(120, "mid");
`ifdef PARAM_RAMP_EN
      wait_tick("mid_load");
      wait_tick("mid_88");
      check("mid_88_gain", o_par_gain, 88);
      wait_tick("mid_96");
      check("mid_96_gain", o_par_gain, 96);
      wait_tick("mid_104");
      check("mid_104_gain", o_par_gain, 104);
      do_write(300, "mid_pend");
`endif
      check("mid_pend_full", o_wr_ready, 0);
      check("mid_busy", o_busy, 1);
      do_reset("rst_mid");
      for (int k = 0; k < 3; k++) begin
         wait_tick("post_rst");
         check("post_rst_gain",  o_par_gain, 80);
         check("post_rst_busy",  o_busy, 0);
         check("post_rst_ready", o_wr_ready, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
